// File: rtl/key_line_pkg.sv
// Shared types and ASCII constants for the keyboard-to-LCD line editor.
package key_line_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      WRITE = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam logic [7:0] ASCII_BS        = 8'h08;
   localparam logic [7:0] ASCII_CR        = 8'h0D;
   localparam logic [7:0] ASCII_SPACE     = 8'h20;
   localparam logic [7:0] ASCII_NONE      = 8'hFF;
   localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
   localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

   function automatic logic is_printable(input logic [7:0] code);
      return (code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX);
   endfunction

endpackage

// File: rtl/key_line_editor_if.sv
// LCD write port between the line editor (master) and the LCD driver (slave).
interface key_line_editor_if #(
   parameter int AW = 5
);
   // Handshake: lcd_busy is the driver's inverted ready. The master raises
   // lcd_wen for exactly one cycle, the cycle after it samples lcd_busy low;
   // the write completes in that cycle. lcd_wen is never high two cycles in a
   // row, and lcd_addr/lcd_din hold from one cycle before lcd_wen until it falls.
   logic          lcd_wen;
   logic [AW-1:0] lcd_addr;
   logic [7:0]    lcd_din;
   logic          lcd_busy;

   modport master (
      output lcd_wen,
      output lcd_addr,
      output lcd_din,
      input  lcd_busy
   );

   modport slave (
      input  lcd_wen,
      input  lcd_addr,
      input  lcd_din,
      output lcd_busy
   );

endinterface

// File: rtl/key_event_detect.sv
// Converts level-style keyboard outputs into single-cycle press events.
// Optional auto-repeat is built only when TYPEMATIC_REPEAT_EN is defined.
module key_event_detect
   import key_line_pkg::*;
#(
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] key_ascii,
   input  logic       key_released,
   output logic       press,
   output logic [7:0] press_ascii
);

   logic       released_prev;
   logic [7:0] ascii_prev;
   logic       edge_press;

   assign edge_press = !key_released && (released_prev || (key_ascii != ascii_prev))
                       && (key_ascii != ASCII_NONE);
   assign press_ascii = key_ascii;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         released_prev <= 1'b1;
         ascii_prev    <= ASCII_NONE;
      end else begin
         released_prev <= key_released;
         ascii_prev    <= key_ascii;
      end
   end

`ifdef TYPEMATIC_REPEAT_EN
   localparam int MAX_WAIT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CW       = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] hold_cnt;
   logic          first_wait;
   logic          held;
   logic          repeat_fire;

   // Counter holds the number of cycles since the last (real or synthesised) press.
   assign held = !key_released && !released_prev && (key_ascii == ascii_prev)
                 && (key_ascii != ASCII_NONE);
   assign repeat_fire = held &&
                        (hold_cnt == (first_wait ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE)));
   assign press = edge_press || repeat_fire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt   <= '0;
         first_wait <= 1'b1;
      end else if (edge_press) begin
         hold_cnt   <= CW'(1);
         first_wait <= 1'b1;
      end else if (repeat_fire) begin
         hold_cnt   <= CW'(1);
         first_wait <= 1'b0;
      end else if (held) begin
         hold_cnt   <= hold_cnt + 1'b1;
      end else begin
         hold_cnt   <= '0;
         first_wait <= 1'b1;
      end
   end
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

   assign press = edge_press;
`endif

endmodule

// File: rtl/key_line_editor.sv
// Cursor/line editor between PS/2 key events and the LCD driver write port.
// Define TYPEMATIC_REPEAT_EN to enable auto-repeat of held keys.
module key_line_editor
   import key_line_pkg::*;
#(
   parameter int  COLS         = 16,
   parameter int  ROWS         = 2,
   parameter int  REPEAT_DELAY = 25_000_000,
   parameter int  REPEAT_RATE  = 5_000_000,
   localparam int CELLS        = COLS * ROWS,
   localparam int AW           = $clog2(CELLS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          key_ascii,
   input  logic                key_released,
   key_line_editor_if.master   lcd,
   output logic [AW-1:0]       cursor,
   output logic                key_dropped,
   output state_t              state_dbg
);

   localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
   localparam logic [AW-1:0] COLS_M1   = AW'(COLS - 1);

   state_t        state;
   logic          advance;
   logic          press;
   logic [7:0]    press_ascii;
   logic [AW-1:0] next_row_start;

   key_event_detect #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
   ) u_detect (
      .clk          (clk),
      .reset        (reset),
      .key_ascii    (key_ascii),
      .key_released (key_released),
      .press        (press),
      .press_ascii  (press_ascii)
   );

   assign state_dbg = state;

   // First cell of the row after the cursor's row; the last row wraps to row 0.
   always_comb begin
      int nxt;
      nxt = (ROWS > 1) ? COLS : 0;
      for (int r = 1; r < ROWS; r++) begin
         if (int'(cursor) >= r * COLS) nxt = (r == ROWS - 1) ? 0 : (r + 1) * COLS;
      end
      next_row_start = AW'(nxt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= INIT;
         lcd.lcd_wen  <= 1'b0;
         lcd.lcd_addr <= '0;
         lcd.lcd_din  <= ASCII_SPACE;
         cursor       <= '0;
         key_dropped  <= 1'b0;
         advance      <= 1'b0;
      end else begin
         // A press arriving while a write sequence is in flight is discarded, not queued.
         key_dropped <= press && (state != IDLE);
         case (state)
            INIT: begin
               if (lcd.lcd_wen) begin
                  lcd.lcd_wen <= 1'b0;
                  if (lcd.lcd_addr == LAST_CELL) begin
                     lcd.lcd_addr <= '0;
                     cursor       <= '0;
                     state        <= IDLE;
                  end else begin
                     lcd.lcd_addr <= lcd.lcd_addr + 1'b1;
                  end
               end else if (!lcd.lcd_busy) begin
                  lcd.lcd_wen <= 1'b1;
               end
            end
            IDLE: begin
               if (press) begin
                  if (press_ascii == ASCII_BS) begin
                     if (cursor != '0) begin
                        cursor       <= cursor - 1'b1;
                        lcd.lcd_addr <= cursor - 1'b1;
                        lcd.lcd_din  <= ASCII_SPACE;
                        advance      <= 1'b0;
                        state        <= WRITE;
                     end
                  end else if (press_ascii == ASCII_CR) begin
                     cursor       <= next_row_start;
                     lcd.lcd_addr <= next_row_start;
                     lcd.lcd_din  <= ASCII_SPACE;
                     state        <= CLEAR;
                  end else if (is_printable(press_ascii)) begin
                     lcd.lcd_addr <= cursor;
                     lcd.lcd_din  <= press_ascii;
                     advance      <= 1'b1;
                     state        <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (lcd.lcd_wen) begin
                  lcd.lcd_wen <= 1'b0;
                  state       <= IDLE;
                  if (advance) cursor <= (cursor == LAST_CELL) ? '0 : cursor + 1'b1;
               end else if (!lcd.lcd_busy) begin
                  lcd.lcd_wen <= 1'b1;
               end
            end
            CLEAR: begin
               // cursor already points at the row start; it marks the row being cleared.
               if (lcd.lcd_wen) begin
                  lcd.lcd_wen <= 1'b0;
                  if (lcd.lcd_addr == cursor + COLS_M1) state <= IDLE;
                  else lcd.lcd_addr <= lcd.lcd_addr + 1'b1;
               end else if (!lcd.lcd_busy) begin
                  lcd.lcd_wen <= 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_key_line_editor.sv
// Self-checking bench for key_line_editor (COLS=16, ROWS=2); typematic checks follow TYPEMATIC_REPEAT_EN.
module tb_key_line_editor;
   import key_line_pkg::*;

   localparam int COLS = 16;
   localparam int ROWS = 2;
   localparam int CELLS = COLS * ROWS;
   localparam int AW = 5;
   localparam int W = AW + 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    key_ascii;
   logic          key_released;
   logic [AW-1:0] cursor;
   logic          key_dropped;
   state_t        state_dbg;

   key_line_editor_if #(.AW(AW)) lcd ();

   key_line_editor #(
      .COLS(COLS), .ROWS(ROWS), .REPEAT_DELAY(20), .REPEAT_RATE(8)
   ) dut (
      .clk(clk), .reset(reset), .key_ascii(key_ascii), .key_released(key_released),
      .lcd(lcd.master), .cursor(cursor), .key_dropped(key_dropped), .state_dbg(state_dbg)
   );

   // clock/reset block
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int passed = 0;

   // write monitor: logs writes and counts handshake violations
   logic          prev_wen = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [7:0]    prev_din = '0;
   int            proto_err = 0;
   logic [W-1:0]  wr_q[$];
   int            wr_cyc[$];

   always @(negedge clk) begin
      if (lcd.lcd_wen === 1'b1) begin
         if (prev_wen) proto_err++;
         if (lcd.lcd_addr !== prev_addr || lcd.lcd_din !== prev_din) proto_err++;
         wr_q.push_back({lcd.lcd_addr, lcd.lcd_din});
         wr_cyc.push_back(cyc);
      end
      prev_wen  = lcd.lcd_wen;
      prev_addr = lcd.lcd_addr;
      prev_din  = lcd.lcd_din;
   end

   bit rand_busy = 1'b0;
   always @(negedge clk) if (rand_busy) lcd.lcd_busy = ($urandom_range(0, 3) == 0);

   // reference model: screen cursor and expected writes
   int           m_cursor = 0;
   logic [W-1:0] exp_q[$];

   function automatic void model_key(input logic [7:0] ch);
      int row;
      if (ch == 8'h08) begin
         if (m_cursor != 0) begin
            m_cursor = m_cursor - 1;
            exp_q.push_back({AW'(m_cursor), 8'h20});
         end
      end else if (ch == 8'h0D) begin
         row = (m_cursor / COLS + 1) % ROWS;
         for (int c = 0; c < COLS; c++) exp_q.push_back({AW'(row * COLS + c), 8'h20});
         m_cursor = row * COLS;
      end else if (ch >= 8'h20 && ch <= 8'h7E) begin
         exp_q.push_back({AW'(m_cursor), ch});
         m_cursor = (m_cursor + 1) % CELLS;
      end
   endfunction

   function automatic logic [7:0] rand_print();
      return 8'($urandom_range(8'h21, 8'h7E));
   endfunction

   // driver tasks
   task automatic press_key(input logic [7:0] ch, input int hold);
      @(negedge clk);
      key_ascii = ch;
      key_released = 1'b0;
      repeat (hold) @(negedge clk);
      key_released = 1'b1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!(state_dbg == IDLE && lcd.lcd_wen == 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) $display("FAIL %s_timeout: state=%0d still busy after %0d cycles", name, state_dbg, budget);
      else passed++;
   endtask

   task automatic type_key(input logic [7:0] ch, input int hold);
      press_key(ch, hold);
      model_key(ch);
      wait_idle(400, "type");
   endtask

   task automatic clear_logs();
      wr_q.delete();
      wr_cyc.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      key_ascii = 8'hFF;
      key_released = 1'b1;
      lcd.lcd_busy = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (lcd.lcd_wen !== 1'b0) $display("FAIL rst_wen: got %b want 0", lcd.lcd_wen); else passed++;
      checks++; if (lcd.lcd_addr !== '0) $display("FAIL rst_addr: got %0d want 0", lcd.lcd_addr); else passed++;
      checks++; if (lcd.lcd_din !== 8'h20) $display("FAIL rst_din: got %h want 20", lcd.lcd_din); else passed++;
      checks++; if (cursor !== '0) $display("FAIL rst_cursor: got %0d want 0", cursor); else passed++;
      checks++; if (key_dropped !== 1'b0) $display("FAIL rst_dropped: got %b want 0", key_dropped); else passed++;
      checks++; if (state_dbg !== INIT) $display("FAIL rst_state: got %0d want INIT", state_dbg); else passed++;
      clear_logs();
      m_cursor = 0;
      for (int i = 0; i < CELLS; i++) exp_q.push_back({AW'(i), 8'h20});
      reset = 1'b0;
      wait_idle(200, "init");
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL init_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL init_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
      checks++; if (cursor !== '0) $display("FAIL init_cursor: got %0d want 0", cursor); else passed++;
   endtask

   task automatic test_typing();
      int t0;
      clear_logs();
      @(negedge clk);
      key_ascii = 8'h61;
      key_released = 1'b0;
      t0 = cyc;
      @(negedge clk);
      key_released = 1'b1;
      model_key(8'h61);
      wait_idle(100, "type_a");
      type_key(8'h62, 2);
      checks++; if (cursor !== 5'd2) $display("FAIL ab_cursor: got %0d want 2", cursor); else passed++;
      checks++;
      if (wr_cyc.size() == 0 || wr_cyc[0] - t0 != 2)
         $display("FAIL press_latency: got %0d want 2", (wr_cyc.size() == 0) ? -1 : wr_cyc[0] - t0);
      else passed++;
      repeat (6) type_key(rand_print(), $urandom_range(1, 3));
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL typing_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL typing_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
      checks++; if (cursor !== AW'(m_cursor)) $display("FAIL typing_cursor: got %0d want %0d", cursor, m_cursor); else passed++;
   endtask

   task automatic test_backspace();
      clear_logs();
      type_key(8'h0D, 2);
      type_key(8'h0D, 2);
      checks++; if (cursor !== '0) $display("FAIL bs_home: got %0d want 0", cursor); else passed++;
      type_key(8'h08, 2);
      checks++; if (wr_q.size() != 2 * COLS) $display("FAIL bs_at_zero_writes: got %0d want %0d", wr_q.size(), 2 * COLS); else passed++;
      repeat (3) type_key(rand_print(), 2);
      type_key(8'h08, 2);
      checks++; if (cursor !== 5'd2) $display("FAIL bs_cursor: got %0d want 2", cursor); else passed++;
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL bs_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL bs_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
   endtask

   task automatic test_enter();
      clear_logs();
      repeat (3) type_key(rand_print(), 2);
      checks++; if (cursor !== 5'd5) $display("FAIL cr_pre: got %0d want 5", cursor); else passed++;
      type_key(8'h0D, 1);
      checks++; if (cursor !== 5'd16) $display("FAIL cr_row1: got %0d want 16", cursor); else passed++;
      repeat (4) type_key(rand_print(), 2);
      type_key(8'h0D, 3);
      checks++; if (cursor !== 5'd0) $display("FAIL cr_wrap: got %0d want 0", cursor); else passed++;
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL cr_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL cr_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
   endtask

   task automatic test_wrap();
      clear_logs();
      repeat (31) type_key(rand_print(), 1);
      checks++; if (cursor !== 5'd31) $display("FAIL wrap_pre: got %0d want 31", cursor); else passed++;
      type_key(8'h7A, 2);
      checks++; if (cursor !== 5'd0) $display("FAIL wrap_cursor: got %0d want 0", cursor); else passed++;
      checks++;
      if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== {5'd31, 8'h7A})
         $display("FAIL wrap_write: got %h want %h", (wr_q.size() == 0) ? 13'h0 : wr_q[wr_q.size() - 1], {5'd31, 8'h7A});
      else passed++;
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL wrap_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
   endtask

   task automatic test_busy();
      int wen_seen = 0;
      clear_logs();
      lcd.lcd_busy = 1'b1;
      @(negedge clk); key_ascii = 8'h71; key_released = 1'b0;
      @(negedge clk); key_released = 1'b1;
      @(negedge clk); key_ascii = 8'h72; key_released = 1'b0;
      @(negedge clk);
      checks++; if (key_dropped !== 1'b1) $display("FAIL busy_dropped: got %b want 1", key_dropped); else passed++;
      key_released = 1'b1;
      @(negedge clk);
      checks++; if (key_dropped !== 1'b0) $display("FAIL busy_dropped_pulse: got %b want 0", key_dropped); else passed++;
      repeat (8) begin
         @(negedge clk);
         if (lcd.lcd_wen) wen_seen++;
      end
      checks++; if (wen_seen != 0 || wr_q.size() != 0) $display("FAIL busy_hold: got %0d strobes want 0", wen_seen + wr_q.size()); else passed++;
      lcd.lcd_busy = 1'b0;
      model_key(8'h71);
      wait_idle(50, "busy_release");
      // press landing in the write-completion cycle is dropped
      @(negedge clk); key_ascii = 8'h6D; key_released = 1'b0;
      @(negedge clk); key_released = 1'b1;
      @(negedge clk);
      checks++; if (lcd.lcd_wen !== 1'b1) $display("FAIL complete_wen: got %b want 1", lcd.lcd_wen); else passed++;
      key_ascii = 8'h6E; key_released = 1'b0;
      @(negedge clk);
      checks++; if (key_dropped !== 1'b1) $display("FAIL complete_dropped: got %b want 1", key_dropped); else passed++;
      key_released = 1'b1;
      model_key(8'h6D);
      wait_idle(50, "complete");
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL busy_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL busy_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
      checks++; if (cursor !== AW'(m_cursor)) $display("FAIL busy_cursor: got %0d want %0d", cursor, m_cursor); else passed++;
   endtask

   task automatic test_random();
      logic [7:0] ch;
      clear_logs();
      rand_busy = 1'b1;
      repeat (40) begin
         case ($urandom_range(0, 9))
            0: ch = 8'h08;
            1: ch = 8'h0D;
            2: ch = 8'hFF;
            3: ch = 8'h01;
            4: ch = 8'h7F;
            default: ch = rand_print();
         endcase
         type_key(ch, $urandom_range(1, 3));
      end
      rand_busy = 1'b0;
      lcd.lcd_busy = 1'b0;
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL rand_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
      checks++; if (cursor !== AW'(m_cursor)) $display("FAIL rand_cursor: got %0d want %0d", cursor, m_cursor); else passed++;
      checks++; if (proto_err != 0) $display("FAIL handshake: got %0d violations want 0", proto_err); else passed++;
   endtask

   task automatic test_mid_reset();
      int n = 0;
      press_key(8'h0D, 1);
      while (lcd.lcd_wen !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n >= 50) $display("FAIL midrst_wait: got no strobe want strobe within 50 cycles"); else passed++;
      #2 reset = 1'b1;
      #1;
      checks++; if (lcd.lcd_wen !== 1'b0) $display("FAIL midrst_wen: got %b want 0", lcd.lcd_wen); else passed++;
      checks++; if (state_dbg !== INIT) $display("FAIL midrst_state: got %0d want INIT", state_dbg); else passed++;
      checks++; if (cursor !== '0) $display("FAIL midrst_cursor: got %0d want 0", cursor); else passed++;
      @(negedge clk);
      clear_logs();
      m_cursor = 0;
      for (int i = 0; i < CELLS; i++) exp_q.push_back({AW'(i), 8'h20});
      reset = 1'b0;
      wait_idle(200, "midrst_init");
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL midrst_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
      end
   endtask

   task automatic test_typematic();
      int t0;
      int exp_rel[$];
`ifdef TYPEMATIC_REPEAT_EN
      exp_rel = '{2, 22, 30, 38};
`else
      exp_rel = '{2};
`endif
      clear_logs();
      @(negedge clk);
      key_ascii = 8'h78;
      key_released = 1'b0;
      t0 = cyc;
      repeat (40) @(negedge clk);
      key_released = 1'b1;
      foreach (exp_rel[i]) model_key(8'h78);
      wait_idle(100, "typematic");
      repeat (10) @(negedge clk);
      checks++; if (wr_q.size() != exp_q.size()) $display("FAIL rep_count: got %0d want %0d", wr_q.size(), exp_q.size()); else passed++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++; if (wr_q[i] !== exp_q[i]) $display("FAIL rep_write%0d: got %h want %h", i, wr_q[i], exp_q[i]); else passed++;
         checks++; if (wr_cyc[i] - t0 != exp_rel[i]) $display("FAIL rep_time%0d: got %0d want %0d", i, wr_cyc[i] - t0, exp_rel[i]); else passed++;
      end
      checks++; if (cursor !== AW'(m_cursor)) $display("FAIL rep_cursor: got %0d want %0d", cursor, m_cursor); else passed++;
   endtask

   initial begin
      test_reset();
      test_typing();
      test_backspace();
      test_enter();
      test_wrap();
      test_busy();
      test_random();
      test_mid_reset();
      test_typematic();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish want finish before 2ms");
      $display("%0d/%0d checks passed", passed, checks + 1);
      $fatal(1, "timeout");
   end

endmodule
